// File: rtl/pdm_word_recorder.sv
// Captures strobed 16-bit PDM words into a sample RAM and replays them in order
// over a valid/ready stream. A three-state FSM arbitrates between record and play.
module pdm_word_recorder #(
    parameter int  DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_record_start,
    input  logic              i_record_stop,
    input  logic              i_play_start,
    input  logic              i_word_valid,
    input  logic [15:0]       i_word_in,
    output logic [15:0]       o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [1:0]        o_state,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_full,
    output logic              o_overflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    state_t              w_state_next;

    logic [15:0]         r_mem [DEPTH];
    logic [15:0]         r_ram_q;

    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_word_count;
    logic                r_full;
    logic                r_overflow;

    logic                r_pend;
    logic                r_pend_last;
    logic                r_issue_done;
    logic [15:0]         r_out_data;
    logic                r_out_valid;
    logic                r_out_last;

    logic                w_wr_en;
    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_issue_last;
    logic                w_clear;
    logic                w_abort;
    logic                w_xfer;
    logic                w_done;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // At most one RAM read is in flight, and one is issued only when the output
    // register is empty or emptying, so a returning word always has a free slot.
    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_rd_en      = 1'b0;
        w_rd_addr    = r_rd_ptr;
        w_clear      = 1'b0;
        w_abort      = 1'b0;
        w_xfer       = r_out_valid && i_out_ready;
        w_done       = r_out_valid && i_out_ready && r_out_last;
        case (r_state)
            S_IDLE: begin
                if (i_record_start) begin
                    w_clear      = 1'b1;
                    w_state_next = S_RECORD;
                end else if (i_play_start && (r_word_count != '0)) begin
                    w_rd_en      = 1'b1;
                    w_rd_addr    = '0;
                    w_state_next = S_PLAY;
                end
            end
            S_RECORD: begin
                if (i_word_valid) begin
                    w_wr_en = 1'b1;
                    if (r_word_count == C_DEPTH - 1'b1) begin
                        w_state_next = S_IDLE;
                    end
                end
                if (i_record_stop) begin
                    w_state_next = S_IDLE;
                end
            end
            S_PLAY: begin
                if (i_record_start) begin
                    w_clear      = 1'b1;
                    w_abort      = 1'b1;
                    w_state_next = S_RECORD;
                end else if (i_record_stop) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_done) begin
                    w_state_next = S_IDLE;
                end else if (!r_issue_done && !r_pend && (!r_out_valid || w_xfer)) begin
                    w_rd_en = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        w_issue_last = ({1'b0, w_rd_addr} == r_word_count - 1'b1);
    end

    always_ff @(posedge i_clock) begin
        if (w_wr_en && !i_reset) begin
            r_mem[r_wr_ptr] <= i_word_in;
        end
        if (w_rd_en) begin
            r_ram_q <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_full       <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_clear) begin
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_full       <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_wr_en) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_word_count <= r_word_count + 1'b1;
            if (r_word_count == C_DEPTH - 1'b1) begin
                r_full <= 1'b1;
            end
        end else if (i_word_valid && r_full) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_ptr     <= '0;
            r_issue_done <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_last  <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            r_pend <= w_rd_en;
            if (w_rd_en) begin
                r_rd_ptr     <= w_rd_addr + 1'b1;
                r_issue_done <= w_issue_last;
                r_pend_last  <= w_issue_last;
            end
            if (w_abort || w_done) begin
                r_out_valid <= 1'b0;
            end else if (r_pend) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_ram_q;
                r_out_last  <= r_pend_last;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_data   = r_out_data;
    assign o_out_valid  = r_out_valid;
    assign o_state      = r_state;
    assign o_word_count = r_word_count;
    assign o_full       = r_full;
    assign o_overflow   = r_overflow;

endmodule
